// File: rtl/sram_arb_pkg.sv
`default_nettype none
// ============================================================================
// Module      : sram_arb_pkg
// Description : Shared definitions for the two-requester SRAM burst arbiter:
//               FSM state encoding, command encodings, default burst length
//               and default first-strobe timeout, plus a command decode helper.
// Revision    : 1.0 - initial release
// ============================================================================
package sram_arb_pkg;

    // Defaults for the arbiter parameters
    localparam int c_BURST_WORDS_DEF = 128;   // 16-bit words per burst (256 bytes)
    localparam int c_TIMEOUT_DEF     = 255;   // max cycles from issue to first strobe

    // Command encodings shared by requesters and the SRAM burst controller.
    // 2'b10 is illegal and is treated exactly like NOP.
    localparam logic [1:0] c_CMD_NOP = 2'b00;
    localparam logic [1:0] c_CMD_WR  = 2'b01;
    localparam logic [1:0] c_CMD_RD  = 2'b11;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_ISSUE = 3'd1,
        ST_WAIT  = 3'd2,
        ST_XFER  = 3'd3,
        ST_GAP   = 3'd4
    } arb_state_t;

    // True only for commands that start a burst
    function automatic logic cmd_is_burst(input logic [1:0] cmd);
        return (cmd == c_CMD_WR) || (cmd == c_CMD_RD);
    endfunction

endpackage : sram_arb_pkg
`default_nettype wire

// File: rtl/sram_arb_grant.sv
`default_nettype none
// ============================================================================
// Module      : sram_arb_grant
// Description : Tie-break logic for the two requesters. With macro
//               SRAM_ARB_ROUND_ROBIN_EN defined, a pointer register remembers
//               which requester wins the next tie and flips to the other
//               requester after every grant. Without the macro, rq0 (video)
//               always wins a tie.
// Ports       : clk     - clock
//               rst     - synchronous active-high reset (pointer -> rq0)
//               i_req0  - rq0 has a burst command pending
//               i_req1  - rq1 has a burst command pending
//               i_load  - a grant is being taken this cycle
//               o_gnt   - winning requester (0 = rq0, 1 = rq1)
// Revision    : 1.0 - initial release
// ============================================================================
module sram_arb_grant (
    input  logic clk,
    input  logic rst,
    input  logic i_req0,
    input  logic i_req1,
    input  logic i_load,
    output logic o_gnt
);

`ifdef SRAM_ARB_ROUND_ROBIN_EN
    // Requester that wins the next tie
    logic r_ptr;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_ptr <= 1'b0;
        end else if (i_load) begin
            r_ptr <= ~o_gnt;
        end
    end

    always_comb begin
        o_gnt = 1'b0;
        if (i_req0 && i_req1) begin
            o_gnt = r_ptr;
        end else if (i_req1) begin
            o_gnt = 1'b1;
        end
    end
`else
    // Fixed priority has no state; the clock, reset and load are unused.
    logic w_unused;
    assign w_unused = ^{clk, rst, i_load};

    always_comb begin
        o_gnt = i_req1 && !i_req0;
    end
`endif

endmodule : sram_arb_grant
`default_nettype wire

// File: rtl/sram_burst_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : sram_burst_arbiter
// Description : Arbitrates two burst requesters (rq0 = video, rq1) onto one
//               SRAM burst controller. A grant is taken in IDLE, the command
//               is issued for one cycle, then the arbiter waits for the first
//               data strobe (bounded by TIMEOUT), counts BURST_WORDS beats and
//               inserts a one-cycle GAP before the next grant.
//               Tie-break policy: SRAM_ARB_ROUND_ROBIN_EN defined selects
//               round-robin, otherwise rq0 has fixed priority.
// Ports       : sys_CLK, sys_RST           - clock, sync active-high reset
//               rq0_CMD/ADDR/DIN           - requester 0 command, address, data
//               rq1_CMD/ADDR/DIN           - requester 1 command, address, data
//               rq_DOUT                    - shared read data
//               rq0_ACK, rq1_ACK           - command-issued pulses
//               rqN_rd_valid, rqN_wr_valid - per-requester data strobes
//               rq_ERR                     - first-strobe timeout pulse
//               mem_CMD/ADDR/DIN           - to SRAM burst controller
//               mem_DOUT, mem_rd/wr_valid  - from SRAM burst controller
// Revision    : 1.0 - initial release
// ============================================================================
module sram_burst_arbiter
    import sram_arb_pkg::*;
#(
    parameter int BURST_WORDS = c_BURST_WORDS_DEF,
    parameter int TIMEOUT     = c_TIMEOUT_DEF
) (
    input  logic        sys_CLK,
    input  logic        sys_RST,
    input  logic [1:0]  rq0_CMD,
    input  logic [1:0]  rq1_CMD,
    input  logic [18:0] rq0_ADDR,
    input  logic [18:0] rq1_ADDR,
    input  logic [15:0] rq0_DIN,
    input  logic [15:0] rq1_DIN,
    output logic [15:0] rq_DOUT,
    output logic        rq0_ACK,
    output logic        rq1_ACK,
    output logic        rq0_rd_valid,
    output logic        rq0_wr_valid,
    output logic        rq1_rd_valid,
    output logic        rq1_wr_valid,
    output logic        rq_ERR,
    output logic [1:0]  mem_CMD,
    output logic [18:0] mem_ADDR,
    output logic [15:0] mem_DIN,
    input  logic [15:0] mem_DOUT,
    input  logic        mem_rd_valid,
    input  logic        mem_wr_valid
);

    // Beat counter holds 0..BURST_WORDS without wrapping
    localparam int c_BEAT_W = $clog2(BURST_WORDS) + 1;
    // Wait counter holds 0..TIMEOUT
    localparam int c_TMO_W  = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

    arb_state_t            r_state;
    arb_state_t            w_state_nxt;
    logic                  r_gnt;        // 0 = rq0, 1 = rq1
    logic [1:0]            r_cmd;
    logic [18:0]           r_addr;
    logic [c_BEAT_W-1:0]   r_beat_cnt;
    logic [c_BEAT_W-1:0]   w_beat_nxt;
    logic [c_BEAT_W-1:0]   w_beat_inc;
    logic [c_TMO_W-1:0]    r_wait_cnt;
    logic [c_TMO_W-1:0]    w_wait_nxt;

    logic                  w_req0;
    logic                  w_req1;
    logic                  w_load;
    logic                  w_arb_gnt;
    logic                  w_mem_valid;
    logic                  w_issue;
    logic                  w_route;
    logic                  w_err;

    assign w_req0      = cmd_is_burst(rq0_CMD);
    assign w_req1      = cmd_is_burst(rq1_CMD);
    assign w_load      = (r_state == ST_IDLE) && (w_req0 || w_req1);
    assign w_mem_valid = mem_rd_valid || mem_wr_valid;
    assign w_beat_inc  = r_beat_cnt + c_BEAT_W'(1);

    sram_arb_grant u_grant (
        .clk    (sys_CLK),
        .rst    (sys_RST),
        .i_req0 (w_req0),
        .i_req1 (w_req1),
        .i_load (w_load),
        .o_gnt  (w_arb_gnt)
    );

    // ------------------------------------------------------------------
    // State and datapath registers
    // ------------------------------------------------------------------
    always_ff @(posedge sys_CLK) begin
        if (sys_RST) begin
            r_state    <= ST_IDLE;
            r_gnt      <= 1'b0;
            r_cmd      <= c_CMD_NOP;
            r_addr     <= '0;
            r_beat_cnt <= '0;
            r_wait_cnt <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_beat_cnt <= w_beat_nxt;
            r_wait_cnt <= w_wait_nxt;
            // Grant, command and address are captured together so the
            // requesters may change their inputs freely after ACK.
            if (w_load) begin
                r_gnt  <= w_arb_gnt;
                r_cmd  <= w_arb_gnt ? rq1_CMD  : rq0_CMD;
                r_addr <= w_arb_gnt ? rq1_ADDR : rq0_ADDR;
            end
        end
    end

    // ------------------------------------------------------------------
    // Next state and control outputs
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        w_beat_nxt  = r_beat_cnt;
        w_wait_nxt  = r_wait_cnt;
        w_issue     = 1'b0;
        w_route     = 1'b0;
        w_err       = 1'b0;

        case (r_state)
            ST_IDLE: begin
                if (w_load) begin
                    w_state_nxt = ST_ISSUE;
                end
            end

            ST_ISSUE: begin
                w_issue     = 1'b1;
                w_beat_nxt  = '0;
                w_wait_nxt  = '0;
                w_state_nxt = ST_WAIT;
            end

            ST_WAIT: begin
                w_route = 1'b1;
                if (w_mem_valid) begin
                    // First strobe is beat 1
                    w_beat_nxt  = c_BEAT_W'(1);
                    w_state_nxt = (BURST_WORDS == 1) ? ST_GAP : ST_XFER;
                end else if (r_wait_cnt == c_TMO_W'(TIMEOUT)) begin
                    // Leaving WAIT for GAP stops strobe routing, which is
                    // how the grant is dropped on a timeout.
                    w_err       = 1'b1;
                    w_state_nxt = ST_GAP;
                end else begin
                    w_wait_nxt = r_wait_cnt + c_TMO_W'(1);
                end
            end

            ST_XFER: begin
                w_route = 1'b1;
                // Staying in XFER implies valid was high last cycle, so a
                // low valid here is the falling edge that ends a short burst.
                if (!w_mem_valid) begin
                    w_state_nxt = ST_GAP;
                end else begin
                    w_beat_nxt = w_beat_inc;
                    if (w_beat_inc == c_BEAT_W'(BURST_WORDS)) begin
                        w_state_nxt = ST_GAP;
                    end
                end
            end

            ST_GAP: begin
                w_state_nxt = ST_IDLE;
            end

            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Datapath muxing
    // ------------------------------------------------------------------
    assign mem_CMD      = w_issue ? r_cmd : c_CMD_NOP;
    assign mem_ADDR     = r_addr;
    assign mem_DIN      = r_gnt ? rq1_DIN : rq0_DIN;
    assign rq_DOUT      = mem_DOUT;

    assign rq0_ACK      = w_issue && !r_gnt;
    assign rq1_ACK      = w_issue &&  r_gnt;
    assign rq_ERR       = w_err;

    assign rq0_rd_valid = w_route && !r_gnt && mem_rd_valid;
    assign rq0_wr_valid = w_route && !r_gnt && mem_wr_valid;
    assign rq1_rd_valid = w_route &&  r_gnt && mem_rd_valid;
    assign rq1_wr_valid = w_route &&  r_gnt && mem_wr_valid;

endmodule : sram_burst_arbiter
`default_nettype wire

// File: tb/tb_sram_burst_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_sram_burst_arbiter
// Description : Self-checking bench for sram_burst_arbiter. Expected issued
//               commands are queued when requests are posted and compared
//               when mem_CMD is seen. A small controller model answers each
//               command with a configurable latency and beat count.
//               Honours SRAM_ARB_ROUND_ROBIN_EN for the expected grant order.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_sram_burst_arbiter;
    import sram_arb_pkg::*;

    localparam int c_BW  = 128;
    localparam int c_TMO = 255;

    logic        sys_CLK = 1'b0;
    logic        sys_RST = 1'b1;
    logic [1:0]  rq0_CMD, rq1_CMD;
    logic [18:0] rq0_ADDR, rq1_ADDR;
    logic [15:0] rq0_DIN, rq1_DIN;
    logic [15:0] rq_DOUT;
    logic        rq0_ACK, rq1_ACK;
    logic        rq0_rd_valid, rq0_wr_valid, rq1_rd_valid, rq1_wr_valid;
    logic        rq_ERR;
    logic [1:0]  mem_CMD;
    logic [18:0] mem_ADDR;
    logic [15:0] mem_DIN;
    logic [15:0] mem_DOUT;
    logic        mem_rd_valid, mem_wr_valid;

    sram_burst_arbiter #(.BURST_WORDS(c_BW), .TIMEOUT(c_TMO)) dut (
        .sys_CLK(sys_CLK), .sys_RST(sys_RST),
        .rq0_CMD(rq0_CMD), .rq1_CMD(rq1_CMD),
        .rq0_ADDR(rq0_ADDR), .rq1_ADDR(rq1_ADDR),
        .rq0_DIN(rq0_DIN), .rq1_DIN(rq1_DIN),
        .rq_DOUT(rq_DOUT),
        .rq0_ACK(rq0_ACK), .rq1_ACK(rq1_ACK),
        .rq0_rd_valid(rq0_rd_valid), .rq0_wr_valid(rq0_wr_valid),
        .rq1_rd_valid(rq1_rd_valid), .rq1_wr_valid(rq1_wr_valid),
        .rq_ERR(rq_ERR),
        .mem_CMD(mem_CMD), .mem_ADDR(mem_ADDR), .mem_DIN(mem_DIN),
        .mem_DOUT(mem_DOUT), .mem_rd_valid(mem_rd_valid), .mem_wr_valid(mem_wr_valid)
    );

    always #5 sys_CLK = ~sys_CLK;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    always @(posedge sys_CLK) cyc++;

    // ---------------- scoreboard ----------------
    typedef struct {
        int          req;
        logic [1:0]  cmd;
        logic [18:0] addr;
    } exp_t;
    exp_t sb[$];
    exp_t mon_e;
    int   glog[$];

    function automatic void sb_push(input int req, input logic [1:0] cmd, input logic [18:0] addr);
        exp_t e;
        e.req = req; e.cmd = cmd; e.addr = addr;
        sb.push_back(e);
    endfunction

    // ---------------- requester drivers ----------------
    int          post0 = 0, post1 = 0, done0 = 0, done1 = 0;
    logic [1:0]  c0 = 2'b00, c1 = 2'b00;
    logic [18:0] a0 = '0, a1 = '0;

    initial begin
        rq0_CMD = 2'b00; rq1_CMD = 2'b00;
        rq0_ADDR = '0;   rq1_ADDR = '0;
        rq0_DIN = '0;    rq1_DIN = '0;
        forever begin
            @(posedge sys_CLK); #2;
            if (rq0_ACK) done0++;
            if (rq1_ACK) done1++;
            rq0_CMD  = (done0 < post0) ? c0 : 2'b00;
            rq1_CMD  = (done1 < post1) ? c1 : 2'b00;
            rq0_ADDR = a0;
            rq1_ADDR = a1;
            rq0_DIN  = 16'($urandom);
            rq1_DIN  = 16'($urandom);
        end
    end

    // ---------------- SRAM controller model ----------------
    int   cfg_lat = 0, cfg_beats = 0;
    int   m_wait = 0, m_left = 0;
    logic m_rd = 1'b0;
    int   kill_req = 0, kill_seen = 0;

    initial begin
        mem_rd_valid = 1'b0; mem_wr_valid = 1'b0; mem_DOUT = '0;
        forever begin
            @(posedge sys_CLK); #1;
            mem_rd_valid = 1'b0;
            mem_wr_valid = 1'b0;
            if (kill_req != kill_seen) begin
                kill_seen = kill_req;
                m_left = 0;
                m_wait = 0;
            end
            if (m_left > 0) begin
                if (m_wait > 0) m_wait--;
                else begin
                    if (m_rd) mem_rd_valid = 1'b1;
                    else      mem_wr_valid = 1'b1;
                    mem_DOUT = 16'($urandom);
                    m_left--;
                end
            end
            if (mem_CMD == c_CMD_RD || mem_CMD == c_CMD_WR) begin
                m_rd   = (mem_CMD == c_CMD_RD);
                m_wait = cfg_lat;
                m_left = cfg_beats;
            end
        end
    end

    // ---------------- monitor ----------------
    int          n_issue = 0, issue_cyc = 0, ack0_n = 0, ack1_n = 0, ack1_cyc = 0;
    int          rd0_n = 0, wr0_n = 0, rd1_n = 0, wr1_n = 0, last0_cyc = 0;
    int          err_n = 0, err_cyc = 0, leak_n = 0, dout_err = 0, din_err = 0, addr_err = 0;
    int          cur_req = 0;
    logic [18:0] cur_addr = '0;

    always @(negedge sys_CLK) begin
        if (mem_CMD !== 2'b00) begin
            n_issue++;
            issue_cyc = cyc;
            checks++;
            if (sb.size() == 0) begin
                errors++;
                $display("FAIL issue_unexpected: mem_CMD=%b mem_ADDR=%h with nothing expected", mem_CMD, mem_ADDR);
            end else begin
                mon_e = sb.pop_front();
                if ({mem_CMD, mem_ADDR, rq0_ACK, rq1_ACK} !==
                    {mon_e.cmd, mon_e.addr, (mon_e.req == 0), (mon_e.req == 1)}) begin
                    errors++;
                    $display("FAIL issue: got cmd=%b addr=%h ack0=%b ack1=%b, expected cmd=%b addr=%h req=%0d",
                             mem_CMD, mem_ADDR, rq0_ACK, rq1_ACK, mon_e.cmd, mon_e.addr, mon_e.req);
                end
            end
            cur_req  = rq1_ACK ? 1 : 0;
            cur_addr = mem_ADDR;
            glog.push_back(cur_req);
        end
        if (rq0_ACK) ack0_n++;
        if (rq1_ACK) begin ack1_n++; ack1_cyc = cyc; end
        if (rq0_rd_valid) rd0_n++;
        if (rq0_wr_valid) wr0_n++;
        if (rq1_rd_valid) rd1_n++;
        if (rq1_wr_valid) wr1_n++;
        if (rq0_rd_valid || rq0_wr_valid) last0_cyc = cyc;
        if (cur_req == 0 && (rq1_rd_valid || rq1_wr_valid)) leak_n++;
        if (cur_req == 1 && (rq0_rd_valid || rq0_wr_valid)) leak_n++;
        if ((rq0_rd_valid || rq1_rd_valid) && rq_DOUT !== mem_DOUT) dout_err++;
        if (rq0_wr_valid && mem_DIN !== rq0_DIN) din_err++;
        if (rq1_wr_valid && mem_DIN !== rq1_DIN) din_err++;
        if ((rq0_rd_valid || rq0_wr_valid || rq1_rd_valid || rq1_wr_valid) && mem_ADDR !== cur_addr) addr_err++;
        if (rq_ERR) begin err_n++; err_cyc = cyc; end
    end

    // ---------------- helpers ----------------
    task automatic tick();
        @(negedge sys_CLK); #1;
    endtask

    task automatic do_reset();
        sys_RST = 1'b1;
        repeat (3) tick();
        sys_RST = 1'b0;
        tick();
    endtask

    task automatic wait_quiet(input string tag);
        int n = 0;
        while (!(done0 == post0 && done1 == post1 && m_left == 0) && n < 2000) begin
            tick();
            n++;
        end
        checks++;
        if (n >= 2000) begin
            errors++;
            $display("FAIL %s_complete: still busy after %0d cycles, required completion", tag, n);
        end
        repeat (4) tick();
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        sys_RST = 1'b1;
        repeat (2) tick();
        checks++;
        if ({mem_CMD, rq0_ACK, rq1_ACK, rq0_rd_valid, rq0_wr_valid,
             rq1_rd_valid, rq1_wr_valid, rq_ERR} !== 9'd0) begin
            errors++;
            $display("FAIL reset_outputs: got cmd=%b ack=%b%b valid=%b%b%b%b err=%b, required all 0",
                     mem_CMD, rq0_ACK, rq1_ACK, rq0_rd_valid, rq0_wr_valid, rq1_rd_valid, rq1_wr_valid, rq_ERR);
        end
        checks++;
        if (mem_ADDR !== 19'd0) begin
            errors++;
            $display("FAIL reset_addr: got %h, required 0", mem_ADDR);
        end
        sys_RST = 1'b0;
        tick();
    endtask

    task automatic test_single_read();
        int b_rd0 = rd0_n, b_o1 = rd1_n + wr1_n, b_ack0 = ack0_n;
        int b_leak = leak_n, b_dout = dout_err, b_addr = addr_err;
        cfg_lat = 3; cfg_beats = c_BW + 12;   // controller offers more than a burst
        c0 = c_CMD_RD; a0 = 19'h00010;
        sb_push(0, c_CMD_RD, 19'h00010);
        post0++;
        wait_quiet("single_read");
        checks++;
        if (rd0_n - b_rd0 !== c_BW) begin
            errors++; $display("FAIL single_read_beats: got %0d, required %0d", rd0_n - b_rd0, c_BW);
        end
        checks++;
        if ((rd1_n + wr1_n - b_o1) !== 0 || leak_n !== b_leak) begin
            errors++; $display("FAIL single_read_rq1_quiet: got %0d strobes, required 0", rd1_n + wr1_n - b_o1);
        end
        checks++;
        if (ack0_n - b_ack0 !== 1) begin
            errors++; $display("FAIL single_read_ack: got %0d pulses, required 1", ack0_n - b_ack0);
        end
        checks++;
        if (dout_err !== b_dout || addr_err !== b_addr) begin
            errors++; $display("FAIL single_read_data: got dout_err=%0d addr_err=%0d, required 0", dout_err - b_dout, addr_err - b_addr);
        end
    endtask

    task automatic test_tie_write();
        int b_wr0, b_wr1, b_din;
        do_reset();
        b_wr0 = wr0_n; b_wr1 = wr1_n; b_din = din_err;
        cfg_lat = 1; cfg_beats = c_BW;
        c0 = c_CMD_WR; a0 = 19'h12345;
        c1 = c_CMD_WR; a1 = 19'h54321;
        sb_push(0, c_CMD_WR, 19'h12345);
        sb_push(1, c_CMD_WR, 19'h54321);
        post0++; post1++;
        wait_quiet("tie_write");
        checks++;
        if (wr0_n - b_wr0 !== c_BW || wr1_n - b_wr1 !== c_BW) begin
            errors++; $display("FAIL tie_write_beats: got rq0=%0d rq1=%0d, required %0d each", wr0_n - b_wr0, wr1_n - b_wr1, c_BW);
        end
        // last rq0 beat, then GAP, one IDLE cycle, then rq1 ISSUE
        checks++;
        if (ack1_cyc - last0_cyc !== 3) begin
            errors++; $display("FAIL tie_write_gap: rq1 ack %0d cycles after last rq0 beat, required 3", ack1_cyc - last0_cyc);
        end
        checks++;
        if (din_err !== b_din) begin
            errors++; $display("FAIL tie_write_din: got %0d bad words, required 0", din_err - b_din);
        end
    endtask

    task automatic test_rr_rounds();
        int b_rd0, b_wr1, b_leak, gn;
        int e0, e1, e2;
        do_reset();
        b_rd0 = rd0_n; b_wr1 = wr1_n; b_leak = leak_n;
        cfg_lat = 0; cfg_beats = 4;
        c0 = c_CMD_RD; a0 = 19'h00100;
        c1 = c_CMD_WR; a1 = 19'h00200;
`ifdef SRAM_ARB_ROUND_ROBIN_EN
        e0 = 0; e1 = 1; e2 = 0;
`else
        e0 = 0; e1 = 0; e2 = 1;
`endif
        sb_push(e0, e0 == 1 ? c_CMD_WR : c_CMD_RD, e0 == 1 ? 19'h00200 : 19'h00100);
        sb_push(e1, e1 == 1 ? c_CMD_WR : c_CMD_RD, e1 == 1 ? 19'h00200 : 19'h00100);
        sb_push(e2, e2 == 1 ? c_CMD_WR : c_CMD_RD, e2 == 1 ? 19'h00200 : 19'h00100);
        post0 += 2; post1 += 1;
        wait_quiet("rr_rounds");
        gn = glog.size();
        checks++;
        if (gn < 3 || glog[gn-3] !== e0 || glog[gn-2] !== e1 || glog[gn-1] !== e2) begin
            errors++;
            $display("FAIL rr_order: got %0d,%0d,%0d, required %0d,%0d,%0d",
                     (gn >= 3) ? glog[gn-3] : -1, (gn >= 2) ? glog[gn-2] : -1, (gn >= 1) ? glog[gn-1] : -1, e0, e1, e2);
        end
        checks++;
        if (rd0_n - b_rd0 !== 8 || wr1_n - b_wr1 !== 4 || leak_n !== b_leak) begin
            errors++; $display("FAIL rr_beats: got rd0=%0d wr1=%0d leak=%0d, required 8 4 0", rd0_n - b_rd0, wr1_n - b_wr1, leak_n - b_leak);
        end
    endtask

    task automatic test_timeout();
        int b_err = err_n, b_rd0 = rd0_n, b_rd1 = rd1_n, t_issue0, n;
        cfg_lat = 0; cfg_beats = 0;           // controller never answers
        c0 = c_CMD_RD; a0 = 19'h7FFFF;
        sb_push(0, c_CMD_RD, 19'h7FFFF);
        post0++;
        repeat (5) tick();
        t_issue0 = issue_cyc;
        c1 = c_CMD_RD; a1 = 19'h00AAA;
        post1++;
        repeat (10) tick();
        a1 = 19'h00BBB;                       // changed while still pending
        sb_push(1, c_CMD_RD, 19'h00BBB);
        n = 0;
        while (err_n == b_err && n < 400) begin tick(); n++; end
        cfg_beats = 4;
        checks++;
        if (err_n == b_err) begin
            errors++; $display("FAIL timeout_err_seen: no rq_ERR after %0d cycles, required one pulse", n);
        end
        checks++;
        if (err_cyc - t_issue0 !== c_TMO + 1) begin
            errors++; $display("FAIL timeout_err_cycle: at WAIT cycle %0d, required %0d", err_cyc - t_issue0, c_TMO + 1);
        end
        wait_quiet("timeout");
        checks++;
        if (err_n - b_err !== 1) begin
            errors++; $display("FAIL timeout_err_pulses: got %0d, required 1", err_n - b_err);
        end
        checks++;
        if (ack1_cyc - err_cyc !== 3 || rd1_n - b_rd1 !== 4 || rd0_n !== b_rd0) begin
            errors++; $display("FAIL timeout_next_grant: ack1 delay %0d rd1=%0d rd0=%0d, required 3 4 0",
                               ack1_cyc - err_cyc, rd1_n - b_rd1, rd0_n - b_rd0);
        end
    endtask

    task automatic test_reset_mid_burst();
        int b_rd0 = rd0_n, b_wr1, b_din, n = 0;
        cfg_lat = 0; cfg_beats = c_BW;
        c0 = c_CMD_RD; a0 = 19'h00ABC;
        sb_push(0, c_CMD_RD, 19'h00ABC);
        post0++;
        while (rd0_n - b_rd0 < 60 && n < 300) begin tick(); n++; end
        sys_RST = 1'b1;
        tick();
        checks++;
        if ({mem_CMD, rq0_rd_valid, rq0_wr_valid, rq1_rd_valid, rq1_wr_valid} !== 6'd0 || mem_ADDR !== 19'd0) begin
            errors++;
            $display("FAIL reset_mid_burst_outputs: got cmd=%b valid=%b%b%b%b addr=%h, required all 0",
                     mem_CMD, rq0_rd_valid, rq0_wr_valid, rq1_rd_valid, rq1_wr_valid, mem_ADDR);
        end
        checks++;
        if (rd0_n - b_rd0 !== 60) begin
            errors++; $display("FAIL reset_mid_burst_beats: got %0d, required 60", rd0_n - b_rd0);
        end
        kill_req++;
        sys_RST = 1'b0;
        tick();
        b_wr1 = wr1_n; b_din = din_err;
        cfg_beats = 8;
        c1 = c_CMD_WR; a1 = 19'h01234;
        sb_push(1, c_CMD_WR, 19'h01234);
        post1++;
        wait_quiet("reset_mid_burst");
        checks++;
        if (wr1_n - b_wr1 !== 8 || din_err !== b_din) begin
            errors++; $display("FAIL reset_mid_burst_after: got wr1=%0d din_err=%0d, required 8 0", wr1_n - b_wr1, din_err - b_din);
        end
    endtask

    task automatic test_illegal();
        int b_iss = n_issue, b_ack = ack1_n, b_rd1;
        c1 = 2'b10; a1 = 19'h00055;
        post1++;
        repeat (30) tick();
        checks++;
        if (n_issue - b_iss !== 0) begin
            errors++; $display("FAIL illegal_issue: got %0d issues, required 0", n_issue - b_iss);
        end
        checks++;
        if (ack1_n - b_ack !== 0) begin
            errors++; $display("FAIL illegal_ack: got %0d acks, required 0", ack1_n - b_ack);
        end
        b_rd1 = rd1_n;
        cfg_lat = 2; cfg_beats = 6;
        sb_push(1, c_CMD_RD, 19'h00055);
        c1 = c_CMD_RD;
        wait_quiet("illegal_then_read");
        checks++;
        if (rd1_n - b_rd1 !== 6) begin
            errors++; $display("FAIL illegal_then_read_beats: got %0d, required 6", rd1_n - b_rd1);
        end
    endtask

    initial begin
        test_reset();
        test_single_read();
        test_tie_write();
        test_rr_rounds();
        test_timeout();
        test_reset_mid_burst();
        test_illegal();
        checks++;
        if (sb.size() != 0) begin
            errors++; $display("FAIL scoreboard_drained: %0d entries left, required 0", sb.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

endmodule : tb_sram_burst_arbiter
`default_nettype wire

// File: doc/sram_burst_arbiter.md
SRAM_BURST_ARBITER -- requirements
Module: sram_burst_arbiter

Interface
REQ-001 SHALL have parameter BURST_WORDS, default 128, meaning 16-bit words per burst (256 bytes).
REQ-002 SHALL have parameter TIMEOUT, default 255, meaning the maximum number of cycles from command issue to the first valid strobe.
REQ-003 sys_CLK  in  1  single clock; all logic is on posedge.
REQ-004 sys_RST  in  1  reset, synchronous, active-high.
REQ-005 rq0_CMD / rq1_CMD  in  2 each  per-requester command: 00=nop, 01=write burst, 11=read burst, 10=illegal, treated as nop; held until ack.
REQ-006 rq0_ADDR / rq1_ADDR  in  19 each  per-requester word address.
REQ-007 rq0_DIN / rq1_DIN  in  16 each  per-requester write data.
REQ-008 rq_DOUT  out  16  read data, shared by both requesters.
REQ-009 rq0_ACK / rq1_ACK  out  1 each  one-cycle pulse when that requester's command is issued downstream.
REQ-010 rq0_rd_valid, rq0_wr_valid, rq1_rd_valid, rq1_wr_valid  out  1 each  per-requester data strobes.
REQ-011 rq_ERR  out  1  one-cycle pulse when a burst times out.
REQ-012 mem_CMD  out  2  command to the SRAM burst controller.
REQ-013 mem_ADDR  out  19  address to the SRAM burst controller.
REQ-014 mem_DIN  out  16  write data to the SRAM burst controller.
REQ-015 mem_DOUT  in  16  read data from the SRAM burst controller.
REQ-016 mem_rd_valid / mem_wr_valid  in  1 each  controller data strobes.

Function
REQ-017 The FSM SHALL have states IDLE, ISSUE, WAIT, XFER and GAP.
REQ-018 IDLE SHALL go to ISSUE when any rqN_CMD is 01 or 11; the grant, command and address SHALL be latched in the same cycle.
REQ-019 ISSUE SHALL drive mem_CMD for exactly one cycle, pulse the granted rqN_ACK in that cycle, and go to WAIT; mem_CMD SHALL be 00 in every other state.
REQ-020 mem_ADDR SHALL hold the latched address from ISSUE until GAP ends.
REQ-021 WAIT SHALL go to XFER on the first mem_rd_valid or mem_wr_valid, and that cycle SHALL count as beat 1.
REQ-022 XFER SHALL count valid beats and go to GAP after BURST_WORDS beats or on a valid falling edge, whichever comes first.
REQ-023 The beat counter SHALL be $clog2(BURST_WORDS)+1 bits wide and SHALL never wrap.
REQ-024 GAP SHALL last one cycle and then return to IDLE; no new grant is made during GAP, so the controller never re-samples a stale command.
REQ-025 Strobes SHALL be routed combinationally to the granted requester only; the other requester's strobes SHALL be 0.
REQ-026 mem_DIN SHALL combinationally mux the granted requester's rqN_DIN.
REQ-027 rq_DOUT SHALL equal mem_DOUT (pass-through).
REQ-028 If WAIT exceeds TIMEOUT cycles, the FSM SHALL pulse rq_ERR, drop the grant and go to GAP.
REQ-029 When both requesters are pending in IDLE, arbitration SHALL follow REQ-034/REQ-035.
REQ-030 A requester whose CMD changes while another burst is in progress SHALL see no effect until its own grant.

Reset
REQ-031 sys_RST SHALL force state IDLE, clear the grant and counters, drive mem_CMD=00, mem_ADDR=0, all ACK, valid and ERR outputs to 0, and set the round-robin pointer to rq0.
REQ-032 Reset asserted mid-burst SHALL abandon the burst, and the strobes SHALL be 0 in the cycle after reset.

Configuration
REQ-033 Macro SRAM_ARB_ROUND_ROBIN_EN SHALL select the arbitration policy.
REQ-034 With SRAM_ARB_ROUND_ROBIN_EN defined: round-robin; after a grant, the other requester wins the next tie.
REQ-035 Without SRAM_ARB_ROUND_ROBIN_EN: fixed priority, rq0 (video) always wins ties.

Structure
REQ-036 Package sram_arb_pkg SHALL hold the state enum, the CMD encodings (NOP/WR/RD) and the BURST_WORDS/TIMEOUT defaults.
REQ-037 A sub-module sram_arb_grant SHALL contain the pure tie-break logic plus the round-robin pointer register.
REQ-038 The FSM and datapath muxing SHALL stay in the top module.

Verification
REQ-039 rq0 read 11 @0x00010 alone -> one-cycle mem_CMD=11 with mem_ADDR=0x00010, rq0_ACK pulse, 128 rq0_rd_valid beats, rq1 strobes 0.
REQ-040 rq0 and rq1 both write in the same cycle, fixed-priority build -> rq0 served first; rq1 issued 1 cycle after rq0's GAP.
REQ-041 Repeat REQ-040 with round-robin build, three rounds -> grant order rq0, rq1, rq0.
REQ-042 Controller model never asserts valid -> rq_ERR pulses at WAIT cycle 256, FSM returns to IDLE, pending rq1 is then granted.
REQ-043 sys_RST asserted at beat 60 of a read -> mem_CMD=00 and all strobes 0 next cycle, state IDLE, new request issued normally afterwards.
REQ-044 CMD=10 on rq1 -> no grant and no ACK; IDLE is maintained.
